sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Parametrised successor of the IF/MEM SRAM arbiter. Arbitrates the instruction-fetch
//  and data ports onto NUM_BANKS external SRAM banks through a req/ack handshake.
//  Adds configurable wait states, out-of-map error response and registered read return.
//  Sits between the IF/MEM pipeline stages and the SRAM pin controllers in the top level.
// PARAMETERS
//  ADDR_W      32             master address width
//  DATA_W      32             data width; byte lanes = DATA_W/8
//  NUM_BANKS   2              number of SRAM banks (>=1)
//  BANK_AW     22             byte-address bits per bank (4 MiB each)
//  BASE_ADDR   32'h8000_0000  start of bank 0; bank k starts at BASE_ADDR + k<<BANK_AW
//  WAIT_CYCLES 1              extra cycles bank_en is held per access (>=0)
// PORTS
//  clk          in   1               clock
//  reset        in   1               asynchronous, active-high reset
//  inst_req     in   1               fetch request; held stable until inst_ack
//  inst_addr    in   ADDR_W          fetch byte address
//  inst_ack     out  1               1-cycle pulse: fetch complete, inst_rdata valid
//  inst_rdata   out  DATA_W          fetch data (registered)
//  inst_err     out  1               with inst_ack: address outside bank map
//  data_req     in   1               data request; held stable until data_ack
//  data_we      in   DATA_W/8        byte write enables; 0 = read
//  data_addr    in   ADDR_W          data byte address
//  data_wdata   in   DATA_W          write data
//  data_ack     out  1               1-cycle pulse: access complete
//  data_rdata   out  DATA_W          read data (registered), 0 after writes
//  data_err     out  1               with data_ack: address outside bank map
//  bank_en      out  NUM_BANKS       one-hot bank chip enable
//  bank_we      out  1               write strobe (shared)
//  bank_be      out  DATA_W/8        byte enables (shared)
//  bank_addr    out  BANK_AW-2       word address within bank (shared)
//  bank_wdata   out  DATA_W          write data (shared)
//  bank_rdata   in   NUM_BANKS*DATA_W read data, bank k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, wait counter 0, rr pointer = inst. Reset mid-access
//    drops bank_en immediately; no ack is issued for the aborted request.
//  - FSM IDLE: if any req, grant one master, latch addr/we/wdata/bank index/hit.
//    hit=1 -> ACCESS; hit=0 -> DONE with err (no bank_en ever asserted).
//  - ACCESS: bank_en[idx]=1, bank_we=|we, bank_be=we or all-ones for reads,
//    bank_addr=addr[BANK_AW-1:2]. Stays WAIT_CYCLES+1 cycles (counter, $clog2 width,
//    min 1 bit); on last cycle capture bank_rdata slice into granted master's rdata.
//  - DONE: pulse granted master's ack (err if miss; rdata 0 on miss/write); -> IDLE.
//  - Latency: req seen at edge N -> ack high in cycle N+WAIT_CYCLES+2 (hit), N+1 (miss).
//    Back-to-back: new grant earliest the cycle after ack (one IDLE cycle).
//  - Arbitration (fixed): data_req beats inst_req when both high in IDLE.
//  - Non-granted master's ack/err stay 0; its rdata holds last value.
//  - Address decode: hit iff BASE_ADDR <= addr < BASE_ADDR + NUM_BANKS<<BANK_AW;
//    idx = (addr-BASE_ADDR)>>BANK_AW. Low 2 address bits ignored for bank_addr.
//  - Requests dropped before ack: undefined for master; arbiter still completes access.
// CONFIGURATION
//  SRAM_ARB_RR_EN defined: round-robin; on simultaneous req the master NOT granted last
//    wins; rr pointer updates on each grant. Single req always granted immediately.
//  SRAM_ARB_RR_EN undefined: fixed priority data > inst as above; no rr pointer.
// STRUCTURE
//  - Package sram_arb_pkg: state enum {IDLE,ACCESS,DONE}, master-id enum {M_INST,M_DATA},
//    localparam BE_W = DATA_W/8.
//  - Sub-module sram_addr_decode (combinational): addr -> {hit, bank idx}.
//  - Top: FSM, wait counter, grant latch, arbitration, output registers.
// TESTING
//  1. Reset: assert reset mid-ACCESS -> bank_en=0 same cycle, no ack, all outputs 0.
//  2. inst_req addr 0x8000_0010, WAIT_CYCLES=1 -> bank_en=2'b01 2 cycles, bank_addr=0x4,
//     inst_ack in cycle N+3 with inst_rdata = bank0 data.
//  3. data write 0x8040_0008 we=4'b0011 wdata 0xDEADBEEF -> bank_en=2'b10, bank_we=1,
//     bank_be=0011, bank_addr=0x2; data_ack, data_rdata=0.
//  4. Both req same cycle, fixed -> data served first, inst ack after; with
//     SRAM_ARB_RR_EN and last grant=data -> inst served first.
//  5. data_req addr 0x9000_0000 -> no bank_en, data_ack+data_err at N+1, rdata 0.
//  6. Continuous both reqs 8 accesses under RR -> grants alternate, no starvation.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM bus arbiter
// Purpose: FSM state and master-id enums, default byte-lane count, width helper.
// Ports: none (package).
package sram_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    M_INST = 1'b0,
    M_DATA = 1'b1
  } master_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_decode.sv
// rtl/sram_bus_arbiter_decode.sv - combinational bank map decoder
// Purpose: maps a master byte address onto the SRAM bank window.
// Ports:
//   addr  in   ADDR_W  master byte address
//   hit   out  1       address lies inside BASE_ADDR .. BASE_ADDR + NUM_BANKS<<BANK_AW
//   idx   out  IDX_W   bank index, meaningful only when hit
module sram_addr_decode #(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_BANKS = 2,
  parameter int                BANK_AW   = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                IDX_W     = 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Window size evaluated in 64 bits so a map reaching the top of the
  // address space cannot wrap.
  localparam logic [63:0] MAP_SIZE = 64'(NUM_BANKS) << BANK_AW;

  logic [ADDR_W-1:0] off;

  always_comb begin
    off = addr - BASE_ADDR;
    hit = (addr >= BASE_ADDR) && (64'(off) < MAP_SIZE);
    idx = IDX_W'(off >> BANK_AW);
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - IF/MEM to multi-bank SRAM req/ack arbiter
// Purpose: grants one of the fetch/data masters, runs a WAIT_CYCLES+1 cycle bank
//   access (or an immediate error completion for out-of-map addresses) and
//   returns registered read data with a one-cycle ack.
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration; default is
//   fixed priority data > inst.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   inst_req/addr                   fetch request, held until inst_ack
//   inst_ack/rdata/err              fetch completion pulse, data, out-of-map flag
//   data_req/we/addr/wdata          data request (we=0 read), held until data_ack
//   data_ack/rdata/err              data completion pulse, data (0 after write), flag
//   bank_en                         one-hot bank chip enable
//   bank_we/be/addr/wdata           shared bank write strobe, lanes, word addr, data
//   bank_rdata                      per-bank read data, bank k at [k*DATA_W +: DATA_W]
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                NUM_BANKS   = 2,
  parameter int                BANK_AW     = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inst_req,
  input  logic [ADDR_W-1:0]           inst_addr,
  output logic                        inst_ack,
  output logic [DATA_W-1:0]           inst_rdata,
  output logic                        inst_err,
  input  logic                        data_req,
  input  logic [DATA_W/8-1:0]         data_we,
  input  logic [ADDR_W-1:0]           data_addr,
  input  logic [DATA_W-1:0]           data_wdata,
  output logic                        data_ack,
  output logic [DATA_W-1:0]           data_rdata,
  output logic                        data_err,
  output logic [NUM_BANKS-1:0]        bank_en,
  output logic                        bank_we,
  output logic [DATA_W/8-1:0]         bank_be,
  output logic [BANK_AW-3:0]          bank_addr,
  output logic [DATA_W-1:0]           bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = clog2_min1(NUM_BANKS);
  localparam int CNT_W = clog2_min1(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  master_e            gnt_q, gnt_d;
  logic [BANK_AW-3:0] waddr_q, waddr_d;
  logic [BYTES-1:0]   we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;

  master_e            gnt_sel;
  logic [ADDR_W-1:0]  addr_sel;
  logic [BYTES-1:0]   we_sel;
  logic [DATA_W-1:0]  wdata_sel;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [DATA_W-1:0]  rd_slice;
  logic               any_req;
  logic               access;
  logic               done;

  assign any_req = inst_req | data_req;

`ifdef SRAM_ARB_RR_EN
  // Last granted master; the other one wins a tie.
  master_e rr_q, rr_d;

  always_comb begin
    if (inst_req && data_req) begin
      gnt_sel = (rr_q == M_DATA) ? M_INST : M_DATA;
    end else begin
      gnt_sel = data_req ? M_DATA : M_INST;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) begin
      rr_d = gnt_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= M_INST;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    gnt_sel = data_req ? M_DATA : M_INST;
  end
`endif

  // Fetches never write, so the inst side of the mux contributes zero lanes/data.
  always_comb begin
    addr_sel  = (gnt_sel == M_DATA) ? data_addr  : inst_addr;
    we_sel    = (gnt_sel == M_DATA) ? data_we    : '0;
    wdata_sel = (gnt_sel == M_DATA) ? data_wdata : '0;
  end

  sram_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_BANKS (NUM_BANKS),
    .BANK_AW   (BANK_AW),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr (addr_sel),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign rd_slice = bank_rdata[int'(idx_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    waddr_d      = waddr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    err_d        = err_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = gnt_sel;
          waddr_d = addr_sel[BANK_AW-1:2];
          we_d    = we_sel;
          wdata_d = wdata_sel;
          idx_d   = dec_idx;
          err_d   = ~dec_hit;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = ACCESS;
          end else begin
            // A miss completes on the next cycle with zero data.
            state_d = DONE;
            if (gnt_sel == M_DATA) begin
              data_rdata_d = '0;
            end else begin
              inst_rdata_d = '0;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (gnt_q == M_DATA) begin
            data_rdata_d = (|we_q) ? '0 : rd_slice;
          end else begin
            inst_rdata_d = rd_slice;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= M_INST;
      waddr_q      <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      waddr_q      <= waddr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Bank pins decode straight from state flops so reset drops them at once.
  assign access = (state_q == ACCESS);
  assign done   = (state_q == DONE);

  assign bank_en    = access ? (NUM_BANKS'(1) << idx_q) : '0;
  assign bank_we    = access & (|we_q);
  assign bank_be    = access ? ((|we_q) ? we_q : '1) : '0;
  assign bank_addr  = access ? waddr_q : '0;
  assign bank_wdata = access ? wdata_q : '0;

  assign inst_ack   = done & (gnt_q == M_INST);
  assign inst_err   = inst_ack & err_q;
  assign inst_rdata = inst_rdata_q;
  assign data_ack   = done & (gnt_q == M_DATA);
  assign data_err   = data_ack & err_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - randomized self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam int NB   = 2;
  localparam int BAW  = 22;
  localparam int W    = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS_PER_BANK = 1 << (BAW - 2);

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_req;
  logic [31:0]       inst_addr;
  logic              inst_ack;
  logic [31:0]       inst_rdata;
  logic              inst_err;
  logic              data_req;
  logic [BE_W-1:0]   data_we;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic              data_ack;
  logic [31:0]       data_rdata;
  logic              data_err;
  logic [NB-1:0]     bank_en;
  logic              bank_we;
  logic [BE_W-1:0]   bank_be;
  logic [BAW-3:0]    bank_addr;
  logic [31:0]       bank_wdata;
  logic [NB*32-1:0]  bank_rdata = '0;

  sram_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .NUM_BANKS(NB), .BANK_AW(BAW),
    .BASE_ADDR(BASE), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .inst_err(inst_err),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .data_err(data_err),
    .bank_en(bank_en), .bank_we(bank_we), .bank_be(bank_be),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents keyed by global word index (bank*WORDS_PER_BANK + word).
  function automatic logic [31:0] init_word(input int key);
    return (key * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] sram [int];     // written only through the DUT bank pins
  logic [31:0] ref_mem [int];  // written by the reference model

  function automatic logic [31:0] sram_rd(input int key);
    return sram.exists(key) ? sram[key] : init_word(key);
  endfunction

  function automatic logic [31:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
  endfunction

  // SRAM banks: act on mid-cycle pin values, present read data for the next edge.
  always @(negedge clk) begin
    int key;
    logic [31:0] w;
    for (int k = 0; k < NB; k++) begin
      key = k * WORDS_PER_BANK + int'(bank_addr);
      if (bank_en[k] && bank_we) begin
        w = sram_rd(key);
        for (int b = 0; b < 4; b++) if (bank_be[b]) w[b*8 +: 8] = bank_wdata[b*8 +: 8];
        sram[key] = w;
      end
      bank_rdata[k*32 +: 32] = sram_rd(key);
    end
  end

  typedef struct {
    bit          hit;
    int          key;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  bit last_data = 1'b0;  // model: last grant went to the data master

  task automatic predict(input bit is_d, input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd, output exp_t e);
    longint off;
    logic [31:0] w;
    off     = longint'(a) - longint'(BASE);
    e.hit   = (off >= 0) && (off < (longint'(NB) << BAW));
    e.key   = int'(off >>> 2);
    e.wr    = is_d && (we != 4'h0);
    e.be    = e.wr ? we : 4'hF;
    e.wdata = wd;
    e.lat   = e.hit ? W + 2 : 1;
    e.rdata = 32'h0;
    if (e.hit) begin
      if (e.wr) begin
        w = ref_rd(e.key);
        for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        ref_mem[e.key] = w;
      end else begin
        e.rdata = ref_rd(e.key);
      end
    end
  endtask

  task automatic run(input bit ir, input logic [31:0] ia, input bit dr, input logic [3:0] dwe,
                     input logic [31:0] da, input logic [31:0] dwd);
    exp_t e [2];
    int first, cur, n, served, c, exp_c, m;
    int en_cnt [2];
    @(negedge clk);
    if (ir && dr) begin
`ifdef SRAM_ARB_RR_EN
      first = last_data ? 0 : 1;
`else
      first = 1;
`endif
    end else begin
      first = dr ? 1 : 0;
    end
    n = (ir && dr) ? 2 : 1;
    // Predict in service order so a data write is visible to a following fetch.
    if (first == 1) begin
      predict(1'b1, da, dwe, dwd, e[1]);
      if (ir) predict(1'b0, ia, 4'h0, 32'h0, e[0]);
    end else begin
      predict(1'b0, ia, 4'h0, 32'h0, e[0]);
      if (dr) predict(1'b1, da, dwe, dwd, e[1]);
    end
    last_data = (n == 2) ? (first == 0) : (first == 1);

    inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
    en_cnt = '{0, 0};
    cur = first; exp_c = e[first].lat; served = 0; c = 0;
    while (served < n && c < 200) begin
      @(negedge clk);
      c++;
      check("ack_onehot", {63'h0, inst_ack & data_ack}, 64'h0);
      check("err_no_ack", {63'h0, (inst_err & ~inst_ack) | (data_err & ~data_ack)}, 64'h0);
      if (bank_en != '0) begin
        en_cnt[cur]++;
        if (e[cur].hit) begin
          check("bank_en", bank_en, 2'(1) << (e[cur].key / WORDS_PER_BANK));
          check("bank_addr", bank_addr, e[cur].key % WORDS_PER_BANK);
          check("bank_we", bank_we, e[cur].wr);
          check("bank_be", bank_be, e[cur].be);
          if (e[cur].wr) check("bank_wdata", bank_wdata, e[cur].wdata);
        end else begin
          check("miss_bank_en", bank_en, 0);
        end
      end
      if (inst_ack || data_ack) begin
        m = data_ack ? 1 : 0;
        check("ack_master", m, cur);
        check("ack_cycle", c, exp_c);
        check("rdata", m ? data_rdata : inst_rdata, e[m].rdata);
        check("err", m ? data_err : inst_err, !e[m].hit);
        check("en_cycles", en_cnt[m], e[m].hit ? W + 1 : 0);
        if (m == 1) data_req = 1'b0; else inst_req = 1'b0;
        served++;
        if (served < n) begin
          cur = 1 - first;
          exp_c = c + 1 + e[cur].lat;
        end
      end
    end
    if (served < n) check("ack_timeout", served, n);
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = BASE + ($urandom_range(0, 15) << 2);
      1: a = BASE + (32'h1 << BAW) + ($urandom_range(0, 15) << 2);
      2: a = BASE - 32'd4;
      3: a = BASE + (32'(NB) << BAW);
      4: a = BASE + (32'(NB) << BAW) - 32'd4;
      5: a = BASE + (32'h1 << BAW) - 32'd4;
      6: a = $urandom;
      default: a = BASE + ($urandom_range(0, 7) << 2);
    endcase
    return a + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int c;
    logic [3:0] we;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {inst_ack, inst_err, data_ack, data_err, bank_en, bank_we,
                          bank_be, bank_addr}, 64'h0);
    check("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
    reset = 1'b0;

    // Reset in the middle of a bank access.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = BASE + 32'h20;
    c = 0;
    do begin @(negedge clk); c++; end while (bank_en == '0 && c < 10);
    check("rst_mid_en_seen", bank_en, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outputs", {inst_ack, inst_err, data_ack, data_err, bank_en, bank_we,
                              bank_be, bank_addr}, 64'h0);
    check("rst_mid_wdata", bank_wdata, 0);
    @(negedge clk);
    inst_req = 1'b0; reset = 1'b0; last_data = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_ack", {inst_ack, data_ack}, 0);
    end

    // Directed cases.
    run(1'b1, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 32'h0);
    run(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8040_0008, 32'hDEAD_BEEF);
    run(1'b0, 32'h0, 1'b1, 4'b0000, 32'h8040_0008, 32'h1234_5678);
    run(1'b0, 32'h0, 1'b1, 4'b0000, 32'h9000_0000, 32'h0);
    run(1'b1, 32'h8040_0008, 1'b1, 4'b1100, 32'h8040_0008, 32'hCAFE_F00D);
    run(1'b1, BASE - 32'd4, 1'b1, 4'b0000, BASE + (32'(NB) << BAW), 32'h0);
    for (int i = 0; i < 8; i++) begin
      run(1'b1, BASE + 32'(i * 4), 1'b1, 4'h0, BASE + (32'h1 << BAW) + 32'(i * 4), 32'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0: run(1'b1, pick_addr(), 1'b0, 4'h0, 32'h0, 32'h0);
        1: run(1'b0, 32'h0, 1'b1, we, pick_addr(), $urandom);
        default: run(1'b1, pick_addr(), 1'b1, we, pick_addr(), $urandom);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
